// File: rtl/sram_resp_ctrl.sv
// LSU word requests become one or two 16-bit async-SRAM half accesses, then a one-cycle response.
// Latency 2*WAIT_CYC+2 (both halves), WAIT_CYC+1 (one half), 1 (empty mask); o_req_rdy stays low until the response has gone out.
module sram_resp_ctrl #(
  parameter int WAIT_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_bmask,
  output logic        o_rsp_vld,
  output logic [31:0] o_rsp_rdata,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  typedef enum logic [2:0] {IDLE, LO, GAP, HI, RSP} state_t;

  typedef struct packed {
    logic        wren;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [3:0]  cnt;
  logic [15:0] rd_lo;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        acc;
  logic [3:0]  acc_mask;
  logic        need_lo_in, need_hi_in, need_hi_q;
  logic        phase_act, phase_end;
  logic [16:0] addr_base;
  logic        unused_addr_bits;

  assign acc        = i_req_vld & (state == IDLE);
  assign acc_mask   = i_req_wren ? i_req_bmask : 4'b1111;
  assign need_lo_in = |acc_mask[1:0];
  assign need_hi_in = |acc_mask[3:2];
  assign need_hi_q  = |req_q.mask[3:2];
  assign phase_act  = (state == LO) || (state == HI);
  assign phase_end  = (cnt == CNT_LAST);
  assign addr_base  = (state == IDLE) ? i_req_addr[18:2] : req_q.addr;
  assign unused_addr_bits = ^{i_req_addr[31:19], i_req_addr[1:0]};

  // The bus is only ever driven during a store phase, when oe_n is high.
  assign io_sram_dq = dq_oe ? dq_out : 16'bz;

  always_comb begin
    state_nxt   = state;
    o_req_rdy   = 1'b0;
    o_rsp_vld   = 1'b0;
    o_sram_ce_n = 1'b1;
    o_sram_we_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_lb_n = 1'b1;
    o_sram_ub_n = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = 16'h0000;
    case (state)
      IDLE: begin
        o_req_rdy = 1'b1;
        if (i_req_vld) begin
          if (need_lo_in)      state_nxt = LO;
          else if (need_hi_in) state_nxt = HI;
          else                 state_nxt = RSP;
        end
      end
      LO, HI: begin
        o_sram_ce_n = 1'b0;
        o_sram_we_n = ~req_q.wren;
        o_sram_oe_n = req_q.wren;
        dq_oe       = req_q.wren;
        if (state == LO) begin
          o_sram_lb_n = ~req_q.mask[0];
          o_sram_ub_n = ~req_q.mask[1];
          dq_out      = req_q.wdata[15:0];
          if (phase_end) state_nxt = need_hi_q ? GAP : RSP;
        end else begin
          o_sram_lb_n = ~req_q.mask[2];
          o_sram_ub_n = ~req_q.mask[3];
          dq_out      = req_q.wdata[31:16];
          if (phase_end) state_nxt = RSP;
        end
      end
      GAP: state_nxt = HI;
      RSP: begin
        o_rsp_vld = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_q       <= '0;
      rd_lo       <= 16'h0000;
      o_rsp_rdata <= 32'h0000_0000;
      o_sram_addr <= 18'h00000;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= 4'd0;
      else if (phase_act)     cnt <= cnt + 4'd1;
      if (acc) req_q <= {i_req_wren, i_req_addr[18:2], i_req_wdata, acc_mask};
      if (state_nxt == LO && state != LO) o_sram_addr <= {addr_base, 1'b0};
      if (state_nxt == HI && state != HI) o_sram_addr <= {addr_base, 1'b1};
      // Load data is captured on the final cycle of each phase, when the SRAM has settled longest.
      if (!req_q.wren && phase_end) begin
        if (state == LO) rd_lo       <= io_sram_dq;
        if (state == HI) o_rsp_rdata <= {io_sram_dq, rd_lo};
      end
    end
  end

endmodule

// File: doc/sram_resp_ctrl.md
Name: sram_resp_ctrl

Overview:
Responder side of the core's data-memory request interface. It accepts 32-bit word load/store requests from the LSU through a valid/ready handshake. Each request becomes one or two 16-bit accesses on the external asynchronous SRAM (18-bit halfword address, 16-bit bidirectional data, active-low strobes). It then returns a single-cycle response pulse, with the assembled read data for loads.

Parameters:
WAIT_CYC, 2, cycles each SRAM half-access phase holds strobes active (legal range 1..15)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_req_vld  input  1  request valid
o_req_rdy  output  1  controller can accept a request
i_req_wren  input  1  1 = store, 0 = load
i_req_addr  input  32  byte address; bits [18:2] used, others ignored
i_req_wdata  input  32  store data
i_req_bmask  input  4  store byte enables, bit n = byte n; ignored for loads
o_rsp_vld  output  1  one-cycle completion pulse
o_rsp_rdata  output  32  load data, valid while o_rsp_vld=1 after a load
o_sram_addr  output  18  SRAM halfword address
io_sram_dq  inout  16  SRAM data bus
o_sram_ce_n  output  1  chip enable, active low
o_sram_we_n  output  1  write enable, active low
o_sram_oe_n  output  1  output enable, active low
o_sram_lb_n  output  1  low-byte enable, active low
o_sram_ub_n  output  1  high-byte enable, active low

Behaviour:
- Reset values (async on i_rst=1):
  - state IDLE
  - o_rsp_vld=0, o_rsp_rdata=0, o_sram_addr=0
  - ce_n/we_n/oe_n/lb_n/ub_n all 1
  - io_sram_dq high-Z
- o_req_rdy = (state==IDLE), combinational from state, so it reads 1 during reset.
- Handshake: a request is accepted on a rising edge with i_req_vld & o_req_rdy. On acceptance the controller latches wren, addr[18:2], wdata and bmask (bmask forced to 4'b1111 for loads). Request inputs are don't-care after acceptance.
- States: IDLE, LO, GAP, HI, RSP.
- Phase counter: 4 bits, cleared on each phase entry. LO and HI each last exactly WAIT_CYC cycles.
- Half-access selection:
  - Low half (bytes 1:0) is needed if mask[1:0]!=0. High half (bytes 3:2) is needed if mask[3:2]!=0.
  - IDLE -> LO if the low half is needed. Else IDLE -> HI if the high half is needed. Else (store with mask 0000) IDLE -> RSP; no SRAM cycle occurs.
  - LO -> GAP after WAIT_CYC cycles if the high half is needed, else LO -> RSP.
  - GAP lasts 1 cycle -> HI.
  - HI -> RSP after WAIT_CYC cycles.
  - RSP lasts 1 cycle -> IDLE.
- SRAM address: o_sram_addr = {addr[18:2],1'b0} in LO and {addr[18:2],1'b1} in HI. It is held through GAP and RSP and changes only on phase entry.
- During LO/HI:
  - ce_n=0.
  - lb_n = ~mask[even byte of half]; ub_n = ~mask[odd byte of half].
  - Store: we_n=0, oe_n=1, dq driven with wdata[15:0] (LO) or wdata[31:16] (HI).
  - Load: we_n=1, oe_n=0, dq high-Z; dq is sampled on the last cycle of the phase into rdata[15:0] or [31:16].
- In GAP, RSP and IDLE: all strobes are 1 and dq is high-Z. GAP guarantees we_n/oe_n deassertion between the two addresses and bus turnaround.
- dq is never driven while oe_n=0.
- RSP: o_rsp_vld=1 for exactly one cycle.
  - Loads: o_rsp_rdata = {hi,lo} sampled data.
  - Stores: o_rsp_rdata holds its previous value.
- Latency from the acceptance edge to o_rsp_vld high:
  - full access: 2*WAIT_CYC+2 cycles
  - single half: WAIT_CYC+1 cycles
  - mask 0000: 1 cycle
- Back-to-back: the next request can be accepted on the cycle after RSP (rdy=1 in IDLE); no request is accepted in RSP.
- Reset mid-operation: the request is aborted and no response is issued. Strobes go inactive and dq is released asynchronously.
- Address bits [31:19] and [1:0] have no effect (word-aligned access only).

Test Plan:
- Reset, then load addr 0x0000_0010, SRAM model holds hw[8]=0xBEEF, hw[9]=0xDEAD -> o_sram_addr 0x00008 then 0x00009, oe_n low 2 cycles each; o_rsp_vld 6 cycles after acceptance with o_rsp_rdata=0xDEADBEEF.
- Store addr 0x0000_0020, wdata 0x12345678, mask 1111 -> hw[0x10]=0x5678, hw[0x11]=0x1234, we_n high in GAP, rsp after 6 cycles.
- Store mask 0100 to addr 0x4, wdata 0x00AB0000 -> only HI phase at 0x00003, lb_n=0, ub_n=1, hw[3] low byte=0xAB, high byte unchanged; rsp after 3 cycles.
- Store mask 0000 -> no ce_n assertion; o_rsp_vld 1 cycle after acceptance; o_rsp_rdata unchanged.
- i_req_vld held high with two queued loads -> second accepted the cycle after first RSP; o_req_rdy=0 for the whole first transaction; exactly two rsp pulses.
- Assert i_rst during the HI phase of a load -> strobes immediately 1, dq high-Z, no rsp pulse, o_req_rdy=1; next load completes correctly.
